// File: rtl/sort_pkg.sv
// sort_pkg: shared state encoding, sort-direction constants and compare helper for sort_engine.
package sort_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_CMP, S_WR0, S_WR1, S_DONE} state_t;
  localparam logic MODE_UP = 1'b1;
  localparam logic MODE_DOWN = 1'b0;
  // Operands arrive pre-extended to one bit wider than any supported element (DATA_W <= 64).
  localparam int CMP_W = 65;
  function automatic logic swap_needed(input logic [CMP_W-1:0] a, input logic [CMP_W-1:0] b,
                                       input logic up, input logic sgn);
    logic gt, lt;
    gt = sgn ? ($signed(a) > $signed(b)) : (a > b);
    lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
    return (up == MODE_DOWN) ? lt : gt;
  endfunction
endpackage

// File: rtl/sort_engine_if.sv
// sort_engine_if: host-side control, load and browse signals of the sort engine.
interface sort_engine_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int CNT_W = 32
);
  logic start, up, sgn, next, prior, ld_we, done;
  logic [ADDR_W-1:0] ld_addr, index;
  logic [DATA_W-1:0] ld_data, data;
  logic [CNT_W-1:0] count;
  modport master (output start, up, sgn, next, prior, ld_we, ld_addr, ld_data,
                  input done, index, data, count);
  modport slave (input start, up, sgn, next, prior, ld_we, ld_addr, ld_data,
                 output done, index, data, count);
endinterface

// File: rtl/sort_ram.sv
// sort_ram: single-port distributed RAM, asynchronous read, synchronous write.
module sort_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/sort_engine.sv
// sort_engine: in-place bubble sort over sort_ram with last-swap pass shortening,
// signed/unsigned compare, host load port and wrap-around browsing when done.
module sort_engine
  import sort_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int CNT_W = 32,
  parameter string INIT_FILE = ""
) (
  input logic          clk,
  input logic          rstn,
  sort_engine_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST = '1;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d, bound_q, bound_d, last_q, last_d, idx1, addr;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] src0_q, src0_d, src1_q, src1_d, rdata, wdata;
  logic swapped_q, swapped_d, up_q, up_d, sgn_q, sgn_d;
  logic busy, ld_sel, upper, we, swap, advance;

  function automatic logic [CMP_W-1:0] ext(input logic [DATA_W-1:0] v, input logic s);
    return {{(CMP_W-DATA_W){s & v[DATA_W-1]}}, v};
  endfunction

  assign busy = !(state_q == S_IDLE || state_q == S_DONE);
  assign ld_sel = !busy && bus.ld_we;
  assign upper = state_q == S_RD1 || state_q == S_WR1;
  assign idx1 = index_q + ADDR_W'(1);
  assign addr = upper ? idx1 : ld_sel ? bus.ld_addr : index_q;
  // No write on a reset edge, so an interrupted swap leaves the RAM untouched.
  assign we = rstn && (state_q == S_WR0 || state_q == S_WR1 || ld_sel);
  assign wdata = state_q == S_WR0 ? src1_q : state_q == S_WR1 ? src0_q : bus.ld_data;
  assign swap = swap_needed(ext(src0_q, sgn_q), ext(src1_q, sgn_q), up_q, sgn_q);

  sort_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INIT_FILE(INIT_FILE)) u_ram (
    .clk(clk), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    count_d = (busy && count_q != '1) ? count_q + CNT_W'(1) : count_q;
    bound_d = bound_q;
    last_d = last_q;
    swapped_d = swapped_q;
    up_d = up_q;
    sgn_d = sgn_q;
    src0_d = src0_q;
    src1_d = src1_q;
    advance = 1'b0;
    case (state_q)
      S_IDLE, S_DONE:
        if (bus.start) begin
          up_d = bus.up;
          sgn_d = bus.sgn;
          count_d = '0;
          index_d = '0;
          bound_d = LAST;
          swapped_d = 1'b0;
          last_d = '0;
          state_d = S_RD0;
        end else if (state_q == S_DONE)
          index_d = index_q + ADDR_W'(bus.next) - ADDR_W'(bus.prior);
      S_RD0: begin
        src0_d = rdata;
        state_d = S_RD1;
      end
      S_RD1: begin
        src1_d = rdata;
        state_d = S_CMP;
      end
      S_CMP: if (swap) state_d = S_WR0; else advance = 1'b1;
      S_WR0: state_d = S_WR1;
      S_WR1: begin
        swapped_d = 1'b1;
        last_d = index_q;
        advance = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Elements beyond the last swap of a pass are already in final position.
    if (advance) begin
      if (idx1 < bound_q) begin
        index_d = idx1;
        state_d = S_RD0;
      end else begin
        index_d = '0;
        state_d = S_DONE;
        if (swapped_d) begin
          bound_d = last_d;
          if (last_d != '0) begin
            swapped_d = 1'b0;
            state_d = S_RD0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk)
    if (!rstn) begin
      state_q <= S_IDLE;
      index_q <= '0;
      count_q <= '0;
      bound_q <= LAST;
      last_q <= '0;
      swapped_q <= 1'b0;
      up_q <= MODE_UP;
      sgn_q <= 1'b0;
      src0_q <= '0;
      src1_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      count_q <= count_d;
      bound_q <= bound_d;
      last_q <= last_d;
      swapped_q <= swapped_d;
      up_q <= up_d;
      sgn_q <= sgn_d;
      src0_q <= src0_d;
      src1_q <= src1_d;
    end

  assign bus.done = !busy;
  assign bus.index = index_q;
  assign bus.data = busy ? '0 : rdata;
  assign bus.count = count_q;
endmodule

// File: tb/tb_sort_engine.sv
// tb_sort_engine: directed bench for sort_engine (DEPTH 8) with a reference sort model.
module tb_sort_engine;
  typedef logic [31:0] arr_t [8];
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  sort_engine_if #(.DATA_W(32), .ADDR_W(3), .CNT_W(32)) bus ();
  sort_engine #(.DATA_W(32), .ADDR_W(3), .CNT_W(32), .INIT_FILE("")) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;
  bit exp_done = 1'b1;
  logic [2:0] exp_idx = 3'd0;
  arr_t exp_mem, m_mem;
  int n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: stable bubble sort; pass bound shrinks to the last swap index.
  task automatic model_run(input bit u, input bit s, output int cyc);
    int b, ls;
    bit sw;
    logic [31:0] t;
    b = 7;
    cyc = 0;
    while (1) begin
      ls = -1;
      for (int i = 0; i < b; i++) begin
        cyc += 3;
        sw = s ? (u ? $signed(m_mem[i]) > $signed(m_mem[i+1]) : $signed(m_mem[i]) < $signed(m_mem[i+1]))
               : (u ? m_mem[i] > m_mem[i+1] : m_mem[i] < m_mem[i+1]);
        if (sw) begin
          t = m_mem[i];
          m_mem[i] = m_mem[i+1];
          m_mem[i+1] = t;
          cyc += 2;
          ls = i;
        end
      end
      if (ls <= 0) break;
      b = ls;
    end
  endtask

  always @(negedge clk)
    if (chk_on) begin
      check("done", 32'(bus.done), 32'(exp_done));
      if (exp_done) begin
        check("index", 32'(bus.index), 32'(exp_idx));
        check("data", bus.data, exp_mem[exp_idx]);
      end else check("busy_data", bus.data, 32'd0);
    end

  task automatic load(input arr_t v);
    chk_on = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 bus.ld_we = 1'b1;
      bus.ld_addr = 3'(i);
      bus.ld_data = v[i];
    end
    @(posedge clk);
    #1 bus.ld_we = 1'b0;
    exp_mem = v;
    m_mem = v;
    chk_on = 1'b1;
  endtask

  task automatic sort(input bit u, input bit s, input int inj, output int cyc);
    model_run(u, s, cyc);
    @(posedge clk);
    #1 bus.start = 1'b1;
    bus.up = u;
    bus.sgn = s;
    @(posedge clk);
    #1 bus.start = 1'b0;
    exp_done = 1'b0;
    for (int c = 1; c <= cyc; c++) begin
      @(posedge clk);
      #1 bus.start = (c == inj);
      bus.ld_we = (c == inj);
      bus.ld_addr = 3'd3;
      bus.ld_data = 32'd99;
    end
    exp_done = 1'b1;
    exp_idx = 3'd0;
    exp_mem = m_mem;
    @(negedge clk);
    check("count_model", bus.count, 32'(cyc));
  endtask

  task automatic browse(input bit nx, input bit pr, input bit moves);
    @(posedge clk);
    #1 bus.next = nx;
    bus.prior = pr;
    @(posedge clk);
    #1 bus.next = 1'b0;
    bus.prior = 1'b0;
    if (moves) exp_idx = exp_idx + 3'(nx) - 3'(pr);
  endtask

  task automatic walk();
    for (int i = 0; i < 8; i++) browse(1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    arr_t asc = '{0, 1, 2, 3, 4, 5, 6, 7};
    arr_t rev = '{7, 6, 5, 4, 3, 2, 1, 0};
    arr_t sv = '{1, 32'hFFFF_FFFF, 0, 2, 3, 4, 5, 6};
    arr_t dv = '{3, 5, 3, 1, 5, 0, 0, 2};
    arr_t dlit = '{5, 5, 3, 3, 2, 1, 0, 0};
    {bus.start, bus.up, bus.sgn, bus.next, bus.prior, bus.ld_we} = '0;
    bus.ld_addr = '0;
    bus.ld_data = '0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_done", 32'(bus.done), 32'd1);
    check("rst_index", 32'(bus.index), 32'd0);
    check("rst_count", bus.count, 32'd0);
    browse(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("idle_browse", 32'(bus.index), 32'd0);

    load(asc);
    sort(1'b1, 1'b0, 0, n);
    check("sorted_count", bus.count, 32'd21);
    walk();

    load(rev);
    sort(1'b1, 1'b0, 0, n);
    check("rev_count", bus.count, 32'd140);
    walk();

    load(sv);
    sort(1'b1, 1'b1, 0, n);
    check("signed_min", bus.data, 32'hFFFF_FFFF);
    load(sv);
    sort(1'b1, 1'b0, 0, n);
    browse(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("wrap_prior", 32'(bus.index), 32'd7);
    check("unsigned_max", bus.data, 32'hFFFF_FFFF);
    browse(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("wrap_next", 32'(bus.index), 32'd0);
    browse(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check("both_pulses", 32'(bus.index), 32'd0);

    load(dv);
    sort(1'b0, 1'b0, 10, n);
    for (int i = 0; i < 8; i++) check("desc_model", m_mem[i], dlit[i]);
    walk();

    load(rev);
    @(posedge clk);
    #1 bus.start = 1'b1;
    bus.up = 1'b1;
    bus.sgn = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    exp_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    exp_done = 1'b1;
    exp_idx = 3'd0;
    @(negedge clk);
    check("midrst_done", 32'(bus.done), 32'd1);
    check("midrst_index", 32'(bus.index), 32'd0);
    check("midrst_count", bus.count, 32'd0);
    sort(1'b1, 1'b0, 0, n);
    check("midrst_resort_count", bus.count, 32'd140);
    walk();

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sort_engine.md
# sort_engine

Parametrised in-place bubble-sort engine over an internal distributed RAM. It is the generalised successor of the lab1 32×1024 sorter: data width, depth and counter width are parameters. It adds signed/unsigned compare, a host load port, last-swap pass shortening with early exit, and wrap-around browsing. It sits between the board I/O layer (buttons, switches, 7-segment display) and its own `sort_ram` instance.

## Interface
- `DATA_W`, 32, element width in bits
- `ADDR_W`, 10, address width; DEPTH = 2^ADDR_W, ADDR_W ≥ 1
- `CNT_W`, 32, cycle-counter width
- `INIT_FILE`, "", optional memory init file passed to `sort_ram`
- Reset is rstn, synchronous, active-low; the clock is clk.
- `clk`  in  1  clock
- `rstn`  in  1  synchronous active-low reset
- `start`  in  1  one-cycle pulse; starts a sort when accepted
- `up`  in  1  1 = ascending, 0 = descending; latched when start is accepted
- `sgn`  in  1  1 = two's-complement compare, 0 = unsigned; latched when start is accepted
- `next`, `prior`  in  1  one-cycle browse pulses (debounced upstream)
- `ld_we`  in  1  host write enable
- `ld_addr`  in  ADDR_W  host write address
- `ld_data`  in  DATA_W  host write data
- `done`  out  1  1 in IDLE or DONE
- `index`  out  ADDR_W  browse or working index
- `data`  out  DATA_W  mem[index] when done = 1, otherwise 0
- `count`  out  CNT_W  cycles spent sorting

## Operation
- **States:** IDLE, RD0, RD1, CMP, WR0, WR1, DONE.
- **Reset values:** state IDLE, index 0, count 0, bound B = DEPTH−1, swapped flag 0, last-swap register L = 0.
- **Start:**
  - Accepted in IDLE or DONE only; ignored while busy.
  - On acceptance: latch up/sgn, clear count, set index 0, set B = DEPTH−1, clear swapped and L, go to RD0.
- **Pair step at index i:**
  - RD0 captures src0 = mem[i].
  - RD1 captures src1 = mem[i+1].
  - CMP evaluates the swap condition: ascending swaps when src0 > src1; descending swaps when src0 < src1.
  - Equal values never swap, so the sort is stable.
  - The compare is signed when sgn = 1 and unsigned otherwise.
- **Swap:** WR0 writes mem[i] = src1, WR1 writes mem[i+1] = src0, then sets swapped = 1 and L = i.
- **Pass continuation:** after CMP (no swap) or WR1, if i+1 < B then index = i+1 and go to RD0.
- **End of pass (i+1 = B):**
  - If swapped = 0, go to DONE.
  - Otherwise set B = L. If the new B = 0, go to DONE; else index = 0, clear swapped, go to RD0.
- **DONE:**
  - Entering DONE forces index = 0.
  - `next` increments index modulo DEPTH; `prior` decrements modulo DEPTH.
  - Both pulses in the same cycle leave index unchanged.
- **Host load:** ld_we writes RAM only when done = 1; it is ignored while busy. Browse pulses in IDLE are ignored.
- **Count:** increments every cycle the state is not IDLE/DONE. It saturates at all-ones.
- **Mid-sort reset:** return to reset values on the next edge. RAM is not restored; partially sorted contents remain.

## Timing
- Non-swap pair costs 3 cycles (RD0, RD1, CMP); swap pair costs 5 cycles.
- RAM read is asynchronous and write is synchronous. The write in WR0/WR1 is visible to a read in the following cycle.
- `data` is combinational from index. The value for a new index is visible in the cycle after the next/prior pulse.
- `done` falls in the cycle after an accepted start. It rises in the cycle after the final CMP or WR1.
- The RAM address mux, by state:
  - RD0/WR0/DONE/IDLE: index, or ld_addr when ld_we = 1.
  - RD1/WR1: index + 1.

## Structure
- Shared package `sort_pkg` holds:
  - the state encoding localparams,
  - the ascending/descending mode constants,
  - a `swap_needed(a, b, up, sgn)` function.
- Sub-module `sort_ram`: parametrised single-port distributed RAM with async read and sync write, with parameters DATA_W, ADDR_W and INIT_FILE. The bench instantiates it with a behavioural model.

## Test plan
Benches use DATA_W = 32, ADDR_W = 3 (DEPTH 8).
- **Sorted input:** load 0..7, up = 1, sgn = 0, start → one pass, 7 pairs, count = 21, RAM unchanged, done = 1.
- **Reverse input:** load 7..0, up = 1 → RAM = 0..7, 28 compares all swapping, count = 140.
- **Signed vs unsigned:** load {1, 0xFFFFFFFF, 0, 2, 3, 4, 5, 6}, up = 1.
  - sgn = 1 → mem[0] = 0xFFFFFFFF.
  - Rerun sgn = 0 on the same input → mem[7] = 0xFFFFFFFF.
- **Descending with duplicates:** load {3, 5, 3, 1, 5, 0, 0, 2}, up = 0 → {5, 5, 3, 3, 2, 1, 0, 0}. A start pulse issued mid-sort and ld_we asserted mid-sort are both ignored.
- **Browse wrap:** in DONE at index 0, prior → index 7 and data = mem[7]. Then next → index 0. Then next and prior together → index stays 0.
- **Reset mid-sort:** rstn low for 1 cycle during WR0 → next cycle done = 1, index = 0, count = 0; a fresh start then completes a correct sort.
